cnn_settle_detect: RTL
======================

// Module: cnn_settle_detect
// PURPOSE
//  Downstream of the 4x4 CNN array (fourbyfour). Watches the 16 free-running state outputs Y1..Y16 each clock.
//  Decides when the network has settled and thresholds each cell to one binary pixel.
//  Presents the 16-bit result on a valid/ready handshake to the next stage.
// PARAMETERS
//  WIDTH          9     template/input width; Y words are 2*WIDTH bits, signed, 8 fractional bits
//  NCELL          16    number of cells monitored
//  STABLE_CYCLES  8     consecutive unchanged cycles required to declare settled (>=1)
//  TOL            0     max |Y(t)-Y(t-1)| in LSBs still counted as unchanged
//  MAX_CYCLES     1024  SETTLE-cycle budget before timeout (only with CNN_SETTLE_TIMEOUT_EN)
// PORTS
//  clk        in   1               system clock, rising edge
//  rst        in   1               asynchronous reset, active-high
//  start      in   1               1-cycle pulse: network restarted, begin monitoring
//  y_flat     in   NCELL*2*WIDTH   Y1 at [2*WIDTH-1:0] ... Y16 in the top word; signed
//  busy       out  1               high in SETTLE
//  out_valid  out  1               result available
//  out_ready  in   1               consumer accepts result
//  out_bits   out  NCELL           bit i-1 = 1 iff Yi > 0 (strictly positive) at capture
//  timeout    out  1               result captured by budget expiry, not by settling
// BEHAVIOUR
//  rst asserted: state=IDLE; busy, out_valid, timeout, out_bits, counters, snapshot all 0.
//  FSM IDLE -> SETTLE on start.
//  FSM SETTLE -> HOLD on settle or timeout.
//  FSM HOLD -> IDLE on out_valid&&out_ready.
//  First SETTLE cycle: load snapshot <= y_flat; no compare; stable_cnt=0; cyc_cnt=1.
//  Later SETTLE cycles: per cell d=Y-snap, computed in 2*WIDTH+1 bits (no overflow).
//   - All |d|<=TOL: stable_cnt++ (saturating).
//   - Otherwise: stable_cnt=0.
//   - Always: snapshot<=y_flat; cyc_cnt++.
//  Settle: the cycle stable_cnt reaches STABLE_CYCLES, out_bits and timeout=0 register from the current y_flat.
//   - out_valid rises next cycle.
//   - Minimum latency start->out_valid = STABLE_CYCLES+2 cycles with constant input.
//  Handshake: out_valid stays high and out_bits/timeout stay stable until out_ready is sampled high.
//   - Transfer occurs on the edge where out_valid&&out_ready; out_valid drops the next cycle.
//   - out_ready is ignored outside HOLD.
//  start in SETTLE: restart, i.e. counters clear and the next cycle is treated as a first cycle.
//  start in HOLD without out_ready: ignored; result is never dropped.
//  start and out_ready in the same HOLD cycle: transfer completes and the FSM goes directly to SETTLE.
//  Settle and timeout in the same cycle: settle wins (timeout=0).
//  rst mid-operation: immediate return to the reset state; a pending result is discarded.
// CONFIGURATION
//  CNN_SETTLE_TIMEOUT_EN defined:
//   - When cyc_cnt==MAX_CYCLES without settling, capture out_bits from current y_flat with timeout=1, go to HOLD.
//  CNN_SETTLE_TIMEOUT_EN undefined:
//   - No cyc_cnt; SETTLE waits indefinitely; timeout tied 0; MAX_CYCLES unused.
// STRUCTURE
//  Package cnn_pkg:
//   - WIDTH, YW=2*WIDTH, NCELL constants.
//   - settle_state_t enum {IDLE,SETTLE,HOLD}.
//   - Counter width function clog2(MAX_CYCLES+1).
//  Sub-module cnn_cell_cmp, instantiated NCELL times:
//   - Inputs y, snap; outputs still (|y-snap|<=TOL) and pos (y>0).
//   - Purely combinational.
//  Top holds FSM, counters, snapshot register and output register.
// TESTING
//  T1 reset: hold rst with y_flat random -> all outputs 0; release -> IDLE, busy=0.
//  T2 constant input: Y6,Y7,Y10,Y11=+256, others=-256; start ->
//   - out_valid at cycle 10 (STABLE_CYCLES=8);
//   - out_bits=16'h0660; timeout=0.
//  T3 late wobble: Y1 toggles +1 LSB on cycles 1..5 then freezes, TOL=0 -> settle cycle counted from the last change.
//   - With TOL=1: settles at cycle 10.
//  T4 backpressure: out_ready=0 for 20 cycles, y_flat changing, start pulsed ->
//   - out_bits/out_valid unchanged;
//   - out_ready=1 together with start -> transfer, then busy=1 next cycle.
//  T5 timeout (macro on, MAX_CYCLES=32): Y1 alternates +/-1 forever ->
//   - out_valid at cycle 33, timeout=1;
//   - macro off: no out_valid after 2000 cycles.
//  T6 mid-run: start re-pulsed at cycle 5 of SETTLE -> latency measured from the second start.
//   - rst at cycle 5 -> IDLE, outputs 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type and counter sizing helper for the CNN settle detector.
package cnn_pkg;

    localparam int unsigned WIDTH = 9;
    localparam int unsigned YW    = 2 * WIDTH;
    localparam int unsigned NCELL = 16;
    localparam int unsigned YFW   = NCELL * YW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } settle_state_t;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cnn_cell_cmp.sv
// Per-cell comparator: change within tolerance against the snapshot, and strict positivity.
module cnn_cell_cmp
    import cnn_pkg::*;
#(
    parameter int unsigned TOL = 0
) (
    input  logic [YW-1:0] y,
    input  logic [YW-1:0] snap,
    output logic          still,
    output logic          pos
);

    localparam int unsigned DW = YW + 1;
    localparam logic signed [DW-1:0] TOL_P = DW'(TOL);
    localparam logic signed [DW-1:0] TOL_N = -TOL_P;

    logic signed [DW-1:0] d;

    // One extra bit keeps the difference of two signed words exact.
    always_comb begin
        d     = $signed({y[YW-1], y}) - $signed({snap[YW-1], snap});
        still = (d <= TOL_P) && (d >= TOL_N);
        pos   = !y[YW-1] && (|y);
    end

endmodule

// File: rtl/cnn_settle_detect.sv
// Settle detector for the 4x4 CNN array: waits for stable Y outputs, thresholds them, hands off via valid/ready.
// Optional budget timeout enabled by defining CNN_SETTLE_TIMEOUT_EN.
module cnn_settle_detect
    import cnn_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned TOL           = 0,
    parameter int unsigned MAX_CYCLES    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [YFW-1:0]   y_flat,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NCELL-1:0] out_bits,
    output logic             timeout
);

    localparam int unsigned SW = cnt_width(STABLE_CYCLES);

    if (STABLE_CYCLES < 1 || MAX_CYCLES < 1) begin : g_bad_cfg
        $error("cnn_settle_detect: STABLE_CYCLES and MAX_CYCLES must be >= 1");
    end

    settle_state_t    state_q, state_d;
    logic [YFW-1:0]   snap_q, snap_d;
    logic [SW-1:0]    stable_q, stable_d;
    logic             first_q, first_d;
    logic [NCELL-1:0] bits_q, bits_d;
    logic             to_q, to_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic [NCELL-1:0] still_v;
    logic [NCELL-1:0] pos_v;
    logic             settle_c;
    logic             expire_c;

`ifdef CNN_SETTLE_TIMEOUT_EN
    localparam int unsigned CW = cnt_width(MAX_CYCLES);
    logic [CW-1:0] cyc_q, cyc_d;
`endif

    for (genvar i = 0; i < NCELL; i++) begin : g_cell
        cnn_cell_cmp #(.TOL(TOL)) u_cmp (
            .y     (y_flat[i*YW +: YW]),
            .snap  (snap_q[i*YW +: YW]),
            .still (still_v[i]),
            .pos   (pos_v[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            snap_q   <= '0;
            stable_q <= '0;
            first_q  <= 1'b0;
            bits_q   <= '0;
            to_q     <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
`ifdef CNN_SETTLE_TIMEOUT_EN
            cyc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            stable_q <= stable_d;
            first_q  <= first_d;
            bits_q   <= bits_d;
            to_q     <= to_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
`ifdef CNN_SETTLE_TIMEOUT_EN
            cyc_q    <= cyc_d;
`endif
        end
    end

    // Next state, snapshot and counters; a start in SETTLE restarts the observation window.
    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        stable_d = stable_q;
        first_d  = first_q;
        settle_c = 1'b0;
        expire_c = 1'b0;
`ifdef CNN_SETTLE_TIMEOUT_EN
        cyc_d    = cyc_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    first_d  = 1'b1;
                    stable_d = '0;
`ifdef CNN_SETTLE_TIMEOUT_EN
                    cyc_d    = '0;
`endif
                end
            end
            SETTLE: begin
                if (start) begin
                    first_d  = 1'b1;
                    stable_d = '0;
`ifdef CNN_SETTLE_TIMEOUT_EN
                    cyc_d    = '0;
`endif
                end else begin
                    snap_d  = y_flat;
                    first_d = 1'b0;
                    if (first_q || !(&still_v)) begin
                        stable_d = '0;
                    end else if (stable_q != SW'(STABLE_CYCLES)) begin
                        stable_d = stable_q + SW'(1);
                    end
                    settle_c = (stable_d == SW'(STABLE_CYCLES));
`ifdef CNN_SETTLE_TIMEOUT_EN
                    cyc_d    = cyc_q + CW'(1);
                    expire_c = !settle_c && (cyc_d == CW'(MAX_CYCLES));
`endif
                    if (settle_c || expire_c) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (valid_q && out_ready) begin
                    if (start) begin
                        state_d  = SETTLE;
                        first_d  = 1'b1;
                        stable_d = '0;
`ifdef CNN_SETTLE_TIMEOUT_EN
                        cyc_d    = '0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register inputs; the result is only captured on the settle/expiry cycle.
    always_comb begin
        bits_d  = bits_q;
        to_d    = to_q;
        busy_d  = (state_d == SETTLE);
        valid_d = (state_d == HOLD);
        if (settle_c) begin
            bits_d = pos_v;
            to_d   = 1'b0;
        end else if (expire_c) begin
            bits_d = pos_v;
            to_d   = 1'b1;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_bits  = bits_q;
    assign timeout   = to_q;

endmodule
